// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable scheduler: config FSM encoding
// and the smallest legal divisor.
package clk_en_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ALIGN = 2'd2
  } cfg_state_e;

  localparam int DIV_MIN = 1;

endpackage

// File: rtl/clk_en_scheduler_if.sv
// Configuration valid/ready port of the clock-enable scheduler.
interface clk_en_scheduler_if #(
  parameter int CH_W      = 2,
  parameter int CNT_WIDTH = 16
);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_div;
  logic                 cfg_align;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_align,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_align,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/clk_en_channel.sv
// One divide-by-N tick generator: divisor register, down-counter and
// registered clk_en pulse, restartable in phase by align.
module clk_en_channel #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 in_clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 run,
  input  logic                 align,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wr_div,
  output logic                 clk_en
);

  logic [CNT_WIDTH-1:0] div_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] reload_s;
  logic                 started_r;
  logic                 clk_en_r;

  assign reload_s = div_r - CNT_WIDTH'(1);
  assign clk_en   = clk_en_r;

  // Divisor register, written by the config FSM
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= CNT_WIDTH'(DEFAULT_DIV);
    end else if (wr) begin
      div_r <= wr_div;
    end
  end

  // Period counter; started_r marks the first active cycle since run rose so
  // that pausing enable resumes the interrupted period instead of reloading
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= CNT_WIDTH'(0);
      started_r <= 1'b0;
      clk_en_r  <= 1'b0;
    end else if (!run) begin
      cnt_r     <= CNT_WIDTH'(0);
      started_r <= 1'b0;
      clk_en_r  <= 1'b0;
    end else if (!enable) begin
      clk_en_r  <= 1'b0;
    end else if (!started_r || align) begin
      cnt_r     <= reload_s;
      started_r <= 1'b1;
      clk_en_r  <= 1'b0;
    end else if (cnt_r == CNT_WIDTH'(0)) begin
      cnt_r     <= reload_s;
      clk_en_r  <= 1'b1;
    end else begin
      cnt_r     <= cnt_r - CNT_WIDTH'(1);
      clk_en_r  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_scheduler.sv
// Multi-channel clock-enable scheduler: NUM_CH programmable tick channels
// plus the config FSM that validates and applies divisor writes.
module clk_en_scheduler
  import clk_en_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                in_clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_run,
  clk_en_scheduler_if.slave   cfg,
  output logic                busy,
  output logic [NUM_CH-1:0]   clk_en
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(NUM_CH);

  cfg_state_e           state_r;
  cfg_state_e           state_s;
  logic [CH_W-1:0]      hold_ch_r;
  logic [CNT_WIDTH-1:0] hold_div_r;
  logic                 hold_align_r;
  logic                 err_r;
  logic                 accept_s;
  logic                 bad_s;
  logic                 wr_s;
  logic                 align_s;
  logic [NUM_CH-1:0]    wr_ch_s;

  assign accept_s      = (state_r == ST_IDLE) && cfg.cfg_valid;
  assign bad_s         = (cfg.cfg_div < CNT_WIDTH'(DIV_MIN)) ||
                         ({1'b0, cfg.cfg_ch} >= CH_LIMIT);
  assign align_s       = (state_r == ST_ALIGN);
  assign cfg.cfg_ready = (state_r == ST_IDLE);
  assign cfg.cfg_err   = err_r;
  assign busy          = (state_r != ST_IDLE);

  // Next-state logic; err_r doubles as the "reject" flag during WRITE
  always_comb begin
    state_s = state_r;
    wr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (err_r) begin
          state_s = ST_IDLE;
        end else if (hold_align_r) begin
          state_s = ST_ALIGN;
          wr_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
          wr_s    = 1'b1;
        end
      end
      ST_ALIGN: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Channel write-strobe decode
  always_comb begin
    wr_ch_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ch_s[i] = wr_s && (hold_ch_r == CH_W'(i));
    end
  end

  // FSM state, holding registers and the registered reject pulse
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      hold_ch_r    <= CH_W'(0);
      hold_div_r   <= CNT_WIDTH'(0);
      hold_align_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      err_r   <= accept_s && bad_s;
      if (accept_s) begin
        hold_ch_r    <= cfg.cfg_ch;
        hold_div_r   <= cfg.cfg_div;
        hold_align_r <= cfg.cfg_align;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .in_clk  (in_clk),
      .reset_n (reset_n),
      .enable  (enable),
      .run     (ch_run[g]),
      .align   (align_s),
      .wr      (wr_ch_s[g]),
      .wr_div  (hold_div_r),
      .clk_en  (clk_en[g])
    );
  end

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Directed bench for clk_en_scheduler: per-cycle vector table plus
// hand-computed pulse masks for config, align, pause and reset sequences.
module tb_clk_en_scheduler;

  logic       in_clk  = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic [3:0] ch_run  = 4'b0000;
  logic       busy;
  logic [3:0] clk_en;
  logic [2:0] ch_run2 = 3'b000;
  logic       busy2;
  logic [2:0] clk_en2;

  int checks   = 0;
  int failures = 0;

  always #5 in_clk = ~in_clk;

  clk_en_scheduler_if #(.CH_W(2), .CNT_WIDTH(16)) cfg ();
  clk_en_scheduler_if #(.CH_W(2), .CNT_WIDTH(16)) cfg2 ();

  clk_en_scheduler #(.NUM_CH(4), .CNT_WIDTH(16), .DEFAULT_DIV(2)) dut (
    .in_clk (in_clk), .reset_n (reset_n), .enable (enable), .ch_run (ch_run),
    .cfg (cfg), .busy (busy), .clk_en (clk_en)
  );

  // Non-power-of-two build to reach an out-of-range channel index
  clk_en_scheduler #(.NUM_CH(3), .CNT_WIDTH(16), .DEFAULT_DIV(2)) dut3 (
    .in_clk (in_clk), .reset_n (reset_n), .enable (enable), .ch_run (ch_run2),
    .cfg (cfg2), .busy (busy2), .clk_en (clk_en2)
  );

  typedef struct {
    logic       en;
    logic [3:0] run;
    logic [3:0] exp_en;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] mask_a;
  logic [31:0] mask_b0;
  logic [31:0] mask_b2;
  logic [31:0] mask_c;
  logic [31:0] mask_d;
  logic [31:0] mask_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic set_cfg(input logic v, input logic [1:0] ch, input logic [15:0] dv, input logic al);
    cfg.cfg_valid = v;
    cfg.cfg_ch    = ch;
    cfg.cfg_div   = dv;
    cfg.cfg_align = al;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    ch_run  = 4'b0000;
    set_cfg(1'b0, 2'd0, 16'd0, 1'b0);
    repeat (2) @(posedge in_clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    cfg2.cfg_valid = 1'b0;
    cfg2.cfg_ch    = 2'd0;
    cfg2.cfg_div   = 16'd0;
    cfg2.cfg_align = 1'b0;
    mask_a  = 32'h0001_0854;  // edges 2,4,6 then 11,16
    mask_b0 = 32'h0000_AA94;  // 2,4 then 7,9,11,13,15
    mask_b2 = 32'h0000_4914;  // 2,4 then 8,11,14
    mask_c  = 32'h0000_3D54;  // 2..10 even, then every edge
    mask_d  = 32'h0000_4080;  // 7, then 14 after 3-cycle pause
    mask_e  = 32'h0000_0014;  // 2,4 at default divisor

    // even-edge pulses on ch0, ch1 joins at edge 6, pause, ch1 drop
    vecs[0]  = '{1'b1, 4'b0001, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0001, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0001, 4'b0001};
    vecs[3]  = '{1'b1, 4'b0001, 4'b0000};
    vecs[4]  = '{1'b1, 4'b0001, 4'b0001};
    vecs[5]  = '{1'b1, 4'b0001, 4'b0000};
    vecs[6]  = '{1'b1, 4'b0011, 4'b0001};
    vecs[7]  = '{1'b1, 4'b0011, 4'b0000};
    vecs[8]  = '{1'b1, 4'b0011, 4'b0011};
    vecs[9]  = '{1'b1, 4'b0011, 4'b0000};
    vecs[10] = '{1'b0, 4'b0011, 4'b0000};
    vecs[11] = '{1'b0, 4'b0011, 4'b0000};
    vecs[12] = '{1'b1, 4'b0011, 4'b0011};
    vecs[13] = '{1'b1, 4'b0011, 4'b0000};
    vecs[14] = '{1'b1, 4'b0001, 4'b0001};
    vecs[15] = '{1'b1, 4'b0001, 4'b0000};

    do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_ready",  32'(cfg.cfg_ready), 32'd1);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_err",    32'(cfg.cfg_err), 32'd0);

    do_reset();
    for (int k = 0; k < 16; k++) begin
      enable = vecs[k].en;
      ch_run = vecs[k].run;
      tick();
      check($sformatf("vec%0d_clk_en", k), 32'(clk_en), 32'(vecs[k].exp_en));
      check($sformatf("vec%0d_ready", k), 32'(cfg.cfg_ready), 32'd1);
    end

    // ch1 divisor 2 -> 5 without align
    do_reset();
    enable = 1'b1;
    ch_run = 4'b0010;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) set_cfg(1'b1, 2'd1, 16'd5, 1'b0);
      else        set_cfg(1'b0, 2'd0, 16'd0, 1'b0);
      tick();
      check($sformatf("div5_ch1_e%0d", k), 32'(clk_en[1]), 32'(mask_a[k]));
      if (k == 3) check("div5_ready_write", 32'(cfg.cfg_ready), 32'd0);
      if (k == 4) check("div5_ready_back", 32'(cfg.cfg_ready), 32'd1);
    end

    // ch2 divisor 3 with align, ch0 and ch2 running
    do_reset();
    enable = 1'b1;
    ch_run = 4'b0101;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) set_cfg(1'b1, 2'd2, 16'd3, 1'b1);
      else        set_cfg(1'b0, 2'd0, 16'd0, 1'b0);
      tick();
      check($sformatf("align_ch0_e%0d", k), 32'(clk_en[0]), 32'(mask_b0[k]));
      check($sformatf("align_ch2_e%0d", k), 32'(clk_en[2]), 32'(mask_b2[k]));
      if (k == 3) check("align_ready_write", 32'(cfg.cfg_ready), 32'd0);
      if (k == 4) check("align_busy_align", 32'(busy), 32'd1);
      if (k == 5) check("align_ready_back", 32'(cfg.cfg_ready), 32'd1);
    end

    // zero divisor rejected, then divisor 1 accepted on ch0
    do_reset();
    enable = 1'b1;
    ch_run = 4'b0001;
    for (int k = 0; k < 14; k++) begin
      if (k == 3)      set_cfg(1'b1, 2'd0, 16'd0, 1'b0);
      else if (k == 7) set_cfg(1'b1, 2'd0, 16'd1, 1'b0);
      else             set_cfg(1'b0, 2'd0, 16'd0, 1'b0);
      tick();
      check($sformatf("err_ch0_e%0d", k), 32'(clk_en[0]), 32'(mask_c[k]));
      if (k == 3) check("err_pulse", 32'(cfg.cfg_err), 32'd1);
      if (k == 3) check("err_busy", 32'(busy), 32'd1);
      if (k == 4) check("err_cleared", 32'(cfg.cfg_err), 32'd0);
      if (k == 8) check("div1_no_err", 32'(cfg.cfg_err), 32'd0);
    end

    // divisor 4 on ch3, enable dropped for three cycles mid-period
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 0) set_cfg(1'b1, 2'd3, 16'd4, 1'b0);
      else        set_cfg(1'b0, 2'd0, 16'd0, 1'b0);
      ch_run = (k >= 3) ? 4'b1000 : 4'b0000;
      enable = (k >= 8 && k <= 10) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("pause_ch3_e%0d", k), 32'(clk_en[3]), 32'(mask_d[k]));
    end

    // reset asserted while the FSM is in WRITE
    do_reset();
    enable = 1'b1;
    ch_run = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) set_cfg(1'b1, 2'd0, 16'd7, 1'b0);
      else        set_cfg(1'b0, 2'd0, 16'd0, 1'b0);
      tick();
    end
    set_cfg(1'b0, 2'd0, 16'd0, 1'b0);
    check("prerst_pulse", 32'(clk_en[0]), 32'd1);
    check("prerst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_clk_en", 32'(clk_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cfg.cfg_ready), 32'd1);
    @(posedge in_clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("postrst_ch0_e%0d", k), 32'(clk_en[0]), 32'(mask_e[k]));
    end

    // channel index range check on the three-channel build
    do_reset();
    cfg2.cfg_valid = 1'b1;
    cfg2.cfg_ch    = 2'd3;
    cfg2.cfg_div   = 16'd5;
    tick();
    check("ch3_of_3_err", 32'(cfg2.cfg_err), 32'd1);
    cfg2.cfg_valid = 1'b0;
    tick();
    check("ch3_of_3_err_end", 32'(cfg2.cfg_err), 32'd0);
    cfg2.cfg_valid = 1'b1;
    cfg2.cfg_ch    = 2'd2;
    cfg2.cfg_div   = 16'd3;
    tick();
    check("ch2_of_3_ok", 32'(cfg2.cfg_err), 32'd0);
    cfg2.cfg_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
